ram_bus_arbiter: RTL and testbench
==================================

RAM_BUS_ARBITER -- requirements
Module: ram_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one Bus (legal 2..8).
REQ-002 Parameter ADDR_W, default 8, Bus Addr width; 256-entry RAM at default.
REQ-003 Parameter DATA_W, default 8, Bus Data width.
REQ-004 One clock; reset is synchronous and active-low. Ports: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-005 req  in  NUM_REQ  per-requester access request, level, held until ack.
REQ-006 req_rwn  in  NUM_REQ  per-requester direction; 1 = read, 0 = write.
REQ-007 req_addr  in  NUM_REQ*ADDR_W  per-requester address; slice i = bits [i*ADDR_W +: ADDR_W].
REQ-008 req_wdata  in  NUM_REQ*DATA_W  per-requester write data, same slicing.
REQ-009 gnt  out  NUM_REQ  one-hot grant, registered.
REQ-010 ack  out  NUM_REQ  one-hot single-cycle completion pulse.
REQ-011 rdata  out  DATA_W  read data returned to the acked requester.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 bus_addr / bus_wdata / bus_rwn / bus_valid  out  ADDR_W / DATA_W / 1 / 1  drive Bus Addr, Data (write), RWn, and access strobe.
REQ-014 bus_rdata  in  DATA_W  Bus Data returned combinationally by the RAM during a read.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, DONE; transitions IDLE->ACCESS (any req), ACCESS->DONE (unconditional), DONE->IDLE (unconditional).
REQ-016 In IDLE with any req bit set, the winner SHALL be chosen round-robin: first set bit searching upward from (last_winner+1) mod NUM_REQ, wrapping.
REQ-017 On the IDLE->ACCESS edge, the winner's addr, rwn, wdata SHALL be latched into bus_addr, bus_rwn, bus_wdata, and gnt set one-hot to the winner.
REQ-018 gnt SHALL remain asserted through ACCESS and DONE and clear on return to IDLE.
REQ-019 bus_valid SHALL be 1 only in ACCESS (exactly one cycle per transaction).
REQ-020 Outside ACCESS, bus_rwn SHALL be 1 (no write possible); bus_addr and bus_wdata hold their last values.
REQ-021 For reads, bus_rdata SHALL be sampled into rdata at the end of ACCESS; for writes, rdata holds its previous value.
REQ-022 In DONE, ack SHALL pulse for the winner only, and last_winner SHALL update to the winner.
REQ-023 Latency: req sampled in cycle N -> gnt and bus_valid in N+1 -> ack and rdata valid in N+2; one transaction per 3 cycles peak.
REQ-024 A requester's inputs changing after the IDLE-cycle sample SHALL NOT affect the transaction in flight.
REQ-025 A req deasserted during ACCESS or DONE SHALL NOT abort; the transaction completes and ack still pulses.
REQ-026 A req held high through ack SHALL be treated as a new request in the next IDLE, at lowest round-robin priority.
REQ-027 With no req in IDLE, the FSM SHALL stay in IDLE with all outputs at idle values.

Reset
REQ-028 rst_n low at a rising edge SHALL force IDLE, gnt=0, ack=0, bus_valid=0, bus_rwn=1, bus_addr=0, bus_wdata=0, rdata=0, busy=0, last_winner=NUM_REQ-1 (requester 0 first).
REQ-029 Reset in ACCESS or DONE SHALL abandon the transaction with no ack issued.

Verification
REQ-030 Single write then read: req[2] writes 0xA5 to 0x3C, then reads 0x3C -> bus_valid one cycle with bus_rwn=0 then 1; second ack[2] at N+2 with rdata=0xA5.
REQ-031 All four req held high from reset -> acks in order 0,1,2,3,0 every 3 cycles; gnt never multi-hot.
REQ-032 last_winner=3, req=4'b1001 -> winner 0 (wrap), then 3 on the following IDLE.
REQ-033 req[1] dropped in ACCESS, req_addr[1] changed to 0xFF -> ack[1] still pulses; bus_addr stays original value.
REQ-034 rst_n low in ACCESS of write 0x11 to 0x80 -> no ack, next cycle bus_valid=0, bus_rwn=1, busy=0.
REQ-035 Idle bench with req=0 for 20 cycles -> state IDLE, bus_valid=0, bus_rwn=1 throughout.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one RAM bus.
// Each transaction takes three cycles: IDLE (arbitrate and latch),
// ACCESS (one bus strobe) and DONE (ack pulse, rotate priority).
module ram_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rwn,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  output logic                      bus_rwn,
  output logic                      bus_valid,
  input  logic [DATA_W-1:0]         bus_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] pick;

  // First set request bit searching upward from last+1, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] p;
    logic             found;
    int               idx;
    p     = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && r[IDX_W'(idx)]) begin
        found = 1'b1;
        p     = IDX_W'(idx);
      end
    end
    return p;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: only IDLE waits; the other two states always advance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration result for the current IDLE cycle.
  always_comb begin
    pick = rr_pick(req, last_winner);
  end

  assign busy = (state != IDLE);

  // Registered bus and handshake outputs. The winner's request is captured
  // on leaving IDLE so later changes on its inputs cannot disturb the access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      winner      <= '0;
      last_winner <= IDX_W'(NUM_REQ - 1);
      gnt         <= '0;
      ack         <= '0;
      bus_valid   <= 1'b0;
      bus_rwn     <= 1'b1;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      rdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            winner    <= pick;
            gnt       <= onehot(pick);
            bus_valid <= 1'b1;
            bus_rwn   <= req_rwn[pick];
            bus_addr  <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
            bus_wdata <= req_wdata[int'(pick)*DATA_W +: DATA_W];
          end
        end
        ACCESS: begin
          bus_valid <= 1'b0;
          bus_rwn   <= 1'b1;
          ack       <= onehot(winner);
          if (bus_rwn) begin
            rdata <= bus_rdata;
          end
        end
        DONE: begin
          ack         <= '0;
          gnt         <= '0;
          last_winner <= winner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: a RAM on the bus, a transaction-level model of
// the arbiter checked every cycle, and directed scenarios with literal values.
module tb_ram_bus_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rwn;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         bus_addr;
  logic [DATA_W-1:0]         bus_wdata;
  logic                      bus_rwn;
  logic                      bus_valid;
  logic [DATA_W-1:0]         bus_rdata;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  ram_bus_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rwn(req_rwn),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
    .rdata(rdata), .busy(busy), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rwn(bus_rwn), .bus_valid(bus_valid), .bus_rdata(bus_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // RAM on the bus: combinational read, write on a sampled write strobe.
  logic [DATA_W-1:0] mem [1<<ADDR_W];
  assign bus_rdata = mem[bus_addr];
  always @(posedge clk) if (bus_valid && !bus_rwn) mem[bus_addr] <= bus_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an in-flight transaction with an age in cycles
  // since the grant (1 = bus strobe cycle, 2 = ack cycle), plus a shadow RAM.
  logic [DATA_W-1:0] shadow [1<<ADDR_W];
  bit                m_busy;
  int                m_age, m_win, m_lw;
  bit                m_rwn;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      // The RAM still commits a write whose strobe it saw at this edge.
      if (m_busy && m_age == 1 && !m_rwn) shadow[m_addr] = m_wdata;
      m_busy = 0; m_age = 0; m_win = 0; m_lw = NUM_REQ - 1;
      m_rwn = 1; m_addr = 0; m_wdata = 0; m_rdata = 0;
    end else if (m_busy) begin
      if (m_age == 1) begin
        if (m_rwn) m_rdata = shadow[m_addr];
        else shadow[m_addr] = m_wdata;
        m_age = 2;
      end else begin
        m_busy = 0;
        m_lw   = m_win;
      end
    end else if (req != 0) begin
      for (int k = NUM_REQ; k >= 1; k--)
        if (req[(m_lw + k) % NUM_REQ]) m_win = (m_lw + k) % NUM_REQ;
      m_rwn   = req_rwn[m_win];
      m_addr  = req_addr[m_win*ADDR_W +: ADDR_W];
      m_wdata = req_wdata[m_win*DATA_W +: DATA_W];
      m_busy  = 1;
      m_age   = 1;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt",       32'(gnt),       m_busy ? (32'd1 << m_win) : 32'd0);
      chk("ack",       32'(ack),       (m_busy && m_age == 2) ? (32'd1 << m_win) : 32'd0);
      chk("bus_valid", 32'(bus_valid), 32'(m_busy && m_age == 1));
      chk("bus_rwn",   32'(bus_rwn),   (m_busy && m_age == 1) ? 32'(m_rwn) : 32'd1);
      chk("bus_addr",  32'(bus_addr),  32'(m_addr));
      chk("bus_wdata", 32'(bus_wdata), 32'(m_wdata));
      chk("rdata",     32'(rdata),     32'(m_rdata));
      chk("busy",      32'(busy),      32'(m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rwn, input logic [7:0] a, input logic [7:0] d);
    req_rwn[i] = rwn;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; req = '0; req_rwn = '1; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i]    = 8'($urandom);
      shadow[i] = mem[i];
    end
    tick(); tick();
    chk_en = 1;

    // Reset values.
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rwn", 32'(bus_rwn), 1);
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rst_n = 1;

    // Write 0xA5 to 0x3C from requester 2, then read it back.
    set_req(2, 0, 8'h3C, 8'hA5);
    req = 4'b0100;
    tick();
    chk("wr_valid", 32'(bus_valid), 1);
    chk("wr_rwn", 32'(bus_rwn), 0);
    chk("wr_addr", 32'(bus_addr), 32'h3C);
    chk("wr_gnt", 32'(gnt), 32'b0100);
    tick();
    chk("wr_ack", 32'(ack), 32'b0100);
    set_req(2, 1, 8'h3C, 8'h00);
    tick();
    chk("idle_gap_gnt", 32'(gnt), 0);
    tick();
    chk("rd_valid", 32'(bus_valid), 1);
    chk("rd_rwn", 32'(bus_rwn), 1);
    tick();
    chk("rd_ack", 32'(ack), 32'b0100);
    chk("rd_data", 32'(rdata), 32'hA5);
    req = '0;
    tick();

    // All four requesting from reset: acks 0,1,2,3,0 three cycles apart.
    rst_n = 0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1, 8'(i), 8'h00);
    req = 4'hF;
    tick();
    rst_n = 1;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'd1 << (t % 4));
      tick();
      chk("rr_ack", 32'(ack), 32'd1 << (t % 4));
      tick();
    end
    req = '0;

    // Wrap from last winner 3: 4'b1001 serves 0 then 3.
    do_reset();
    req = 4'b1001;
    tick(); tick();
    chk("wrap_ack0", 32'(ack), 32'b0001);
    tick(); tick(); tick();
    chk("wrap_ack3", 32'(ack), 32'b1000);
    req = '0;
    tick();

    // Requester 1 drops req and changes address mid-transaction.
    do_reset();
    set_req(1, 1, 8'h21, 8'h00);
    req = 4'b0010;
    tick();
    req = '0;
    set_req(1, 1, 8'hFF, 8'h00);
    chk("drop_addr_acc", 32'(bus_addr), 32'h21);
    tick();
    chk("drop_ack", 32'(ack), 32'b0010);
    chk("drop_addr_done", 32'(bus_addr), 32'h21);
    tick();

    // Reset during the ACCESS of a write abandons it.
    set_req(0, 0, 8'h80, 8'h11);
    req = 4'b0001;
    tick();
    chk("abort_valid_pre", 32'(bus_valid), 1);
    rst_n = 0;
    req = '0;
    tick();
    rst_n = 1;
    chk("abort_ack", 32'(ack), 0);
    chk("abort_valid", 32'(bus_valid), 0);
    chk("abort_rwn", 32'(bus_rwn), 1);
    chk("abort_busy", 32'(busy), 0);
    tick();
    chk("abort_ack_after", 32'(ack), 0);

    // Idle for 20 cycles.
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("idle_valid", 32'(bus_valid), 0);
      chk("idle_rwn", 32'(bus_rwn), 1);
      chk("idle_busy", 32'(busy), 0);
    end

    // Randomised traffic with occasional resets; inputs change every cycle.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst_n = 1;
    req = '0;
    tick(); tick(); tick();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
